// File: rtl/key_event_queue.sv
// Key event FIFO: enqueues one-hot key pulses as 2-bit codes and hands them
// to a consumer, flagging drops while full and rejecting multi-hot inputs.
module key_event_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 key_val,
  input  logic                       clr,
  input  logic                       evt_ready,
  output logic                       evt_valid,
  output logic [1:0]                 evt_code,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       overflow,
  output logic                       bad_evt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic          bad_q;

  logic          key_any;
  logic          key_onehot;
  logic          key_multi;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [1:0]    key_code;

  always_comb begin
    key_code = 2'd0;
    case (key_val)
      4'b0001: key_code = 2'd0;
      4'b0010: key_code = 2'd1;
      4'b0100: key_code = 2'd2;
      4'b1000: key_code = 2'd3;
      default: key_code = 2'd0;
    endcase
  end

  // Handshake: a transfer happens on the rising edge where evt_valid and
  // evt_ready are both 1; evt_code holds the head entry until then.
  assign key_any    = |key_val;
  assign key_onehot = key_any && ((key_val & (key_val - 4'd1)) == 4'd0);
  assign key_multi  = key_any && !key_onehot;
  assign full       = (count == FULL_COUNT);
  assign pop        = (count != '0) && evt_ready && !clr;
  // A pop in the same cycle frees the slot the new event lands in.
  assign push       = key_onehot && !clr && (!full || pop);
  assign drop       = key_onehot && !clr && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else if (clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
      bad_q <= key_multi;
    end
  end

  // Storage is not reset; the output mux masks stale data when empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= key_code;
    end
  end

  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? mem[rd_ptr] : 2'd0;
  assign evt_count = count;
  assign overflow  = overflow_q;
  assign bad_evt   = bad_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios with literal expectations plus
// random traffic checked every cycle against a queue-based reference model.
module tb_key_event_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    key_val = 4'b0000;
  logic          clr = 1'b0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_code;
  logic [CW-1:0] evt_count;
  logic          overflow;
  logic          bad_evt;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic       model_ovf = 1'b0;
  logic       model_bad = 1'b0;

  key_event_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_val   (key_val),
    .clr       (clr),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_count (evt_count),
    .overflow  (overflow),
    .bad_evt   (bad_evt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of codes, sticky overflow, one-cycle bad flag
  always @(posedge clk) begin
    int ones;
    logic [1:0] code;
    ones = $countones(key_val);
    code = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (key_val[b]) code = 2'(b);
    end
    if (rst || clr) begin
      exp_q.delete();
      model_ovf = 1'b0;
      model_bad = 1'b0;
    end else begin
      if (exp_q.size() != 0 && evt_ready) begin
        void'(exp_q.pop_front());
      end
      if (ones == 1) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(code);
        else model_ovf = 1'b1;
      end
      model_bad = (ones >= 2);
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    chk("model_valid", 8'(evt_valid), 8'(exp_q.size() != 0));
    chk("model_code", 8'(evt_code), (exp_q.size() != 0) ? 8'(exp_q[0]) : 8'd0);
    chk("model_count", 8'(evt_count), 8'(exp_q.size()));
    chk("model_overflow", 8'(overflow), 8'(model_ovf));
    chk("model_bad_evt", 8'(bad_evt), 8'(model_bad));
  end

  // driver: apply inputs for one cycle, return just after the edge
  task automatic cyc(input logic [3:0] k, input logic c, input logic r, input logic rs);
    key_val   = k;
    clr       = c;
    evt_ready = r;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    cyc(4'b0000, 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [3:0] k;
    int rv;

    // reset
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 8'(evt_valid), 8'd0);
    chk("rst_code", 8'(evt_code), 8'd0);
    chk("rst_count", 8'(evt_count), 8'd0);
    chk("rst_overflow", 8'(overflow), 8'd0);
    chk("rst_bad", 8'(bad_evt), 8'd0);

    // single event and hold
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("single_valid", 8'(evt_valid), 8'd1);
    chk("single_code", 8'(evt_code), 8'd2);
    chk("single_count", 8'(evt_count), 8'd1);
    idle(1'b0);
    chk("single_hold_code", 8'(evt_code), 8'd2);
    idle(1'b1);
    chk("single_popped", 8'(evt_valid), 8'd0);

    // order and wrap
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("wrap_peak", 8'(evt_count), 8'd4);
    chk("wrap_head0", 8'(evt_code), 8'd0);
    idle(1'b1);
    chk("wrap_head1", 8'(evt_code), 8'd1);
    idle(1'b1);
    chk("wrap_head2", 8'(evt_code), 8'd2);
    idle(1'b1);
    chk("wrap_head3", 8'(evt_code), 8'd3);
    idle(1'b1);
    chk("wrap_empty", 8'(evt_count), 8'd0);
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("wrap_head_3b", 8'(evt_code), 8'd3);
    idle(1'b1);
    chk("wrap_head_0b", 8'(evt_code), 8'd0);
    idle(1'b1);
    chk("wrap_done", 8'(evt_count), 8'd0);
    chk("wrap_no_ovf", 8'(overflow), 8'd0);

    // overflow and simultaneous push/pop while full
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 8'(overflow), 8'd1);
    chk("ovf_count", 8'(evt_count), 8'd4);
    chk("ovf_head", 8'(evt_code), 8'd0);
    cyc(4'b0010, 1'b0, 1'b1, 1'b0);
    chk("pushpop_count", 8'(evt_count), 8'd4);
    chk("pushpop_head", 8'(evt_code), 8'd1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("pushpop_last", 8'(evt_code), 8'd1);
    chk("pushpop_last_cnt", 8'(evt_count), 8'd1);
    idle(1'b1);
    chk("ovf_sticky", 8'(overflow), 8'd1);

    // multi-hot rejection
    cyc(4'b0011, 1'b0, 1'b0, 1'b0);
    chk("multi_bad", 8'(bad_evt), 8'd1);
    chk("multi_count", 8'(evt_count), 8'd0);
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("multi_after_bad", 8'(bad_evt), 8'd0);
    chk("multi_after_code", 8'(evt_code), 8'd3);

    // clr with a key in the same cycle
    cyc(4'b0001, 1'b0, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("clr_pre_count", 8'(evt_count), 8'd3);
    chk("clr_pre_ovf", 8'(overflow), 8'd1);
    cyc(4'b0001, 1'b1, 1'b0, 1'b0);
    chk("clr_count", 8'(evt_count), 8'd0);
    chk("clr_valid", 8'(evt_valid), 8'd0);
    chk("clr_ovf", 8'(overflow), 8'd0);
    chk("clr_bad", 8'(bad_evt), 8'd0);

    // reset mid-operation
    cyc(4'b0100, 1'b0, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0, 1'b1);
    chk("midrst_valid", 8'(evt_valid), 8'd0);
    chk("midrst_code", 8'(evt_code), 8'd0);
    chk("midrst_count", 8'(evt_count), 8'd0);
    cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("midrst_push_valid", 8'(evt_valid), 8'd1);
    chk("midrst_push_code", 8'(evt_code), 8'd1);

    // randomized traffic, alternating consumer speed to reach full often
    for (int i = 0; i < 3000; i++) begin
      rv = $urandom_range(0, 99);
      if (rv < 35) begin
        k = 4'b0000;
      end else if (rv < 85) begin
        k = 4'b0001 << $urandom_range(0, 3);
      end else begin
        k = 4'(($urandom_range(0, 15)));
        while ($countones(k) < 2) k = 4'(($urandom_range(0, 15)));
      end
      cyc(k,
          ($urandom_range(0, 99) < 2),
          (((i / 150) % 2) == 1) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 199) == 0));
    end
    cyc(4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: key_val  input  4  one-hot single-cycle key pulses from the debounce filter; 4'b0000 = no event.
REQ-005 Port: clr  input  1  synchronous flush request.
REQ-006 Port: evt_ready  input  1  consumer ready.
REQ-007 Port: evt_valid  output  1  head entry available.
REQ-008 Port: evt_code  output  2  encoded key index of head entry.
REQ-009 Port: evt_count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 Port: overflow  output  1  sticky; an event was dropped while full.
REQ-011 Port: bad_evt  output  1  one-cycle pulse; multi-hot key_val rejected.

Function
REQ-012 Encoding SHALL be: 4'b0001->0, 4'b0010->1, 4'b0100->2, 4'b1000->3.
REQ-013 Push SHALL occur on the rising edge ending any cycle with key_val one-hot, clr=0, and the queue either not full or popping that same cycle.
REQ-014 Pop SHALL occur on the rising edge where evt_valid=1 and evt_ready=1 and clr=0.
REQ-015 Latency: with the queue empty, key_val one-hot in cycle N SHALL produce evt_valid=1 with the matching evt_code in cycle N+1.
REQ-016 evt_valid SHALL equal (evt_count != 0); evt_code SHALL show the oldest entry and stay stable while evt_valid=1 and evt_ready=0.
REQ-017 Order SHALL be strict FIFO; read/write pointers wrap modulo DEPTH with no lost or duplicated entry.
REQ-018 evt_count SHALL behave as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 Full with push and pop in the same cycle: both SHALL be performed; count stays DEPTH; overflow unchanged.
REQ-020 Full with one-hot key_val and no pop: the event SHALL be dropped; contents unchanged; overflow set to 1 next cycle.
REQ-021 overflow SHALL remain 1 until rst or clr.
REQ-022 key_val with two or more bits set SHALL NOT be enqueued; bad_evt SHALL be 1 for exactly the next cycle.
REQ-023 One-hot key_val SHALL leave bad_evt 0; key_val=0 SHALL have no effect.
REQ-024 Empty with evt_ready=1: no pop; count SHALL stay 0.
REQ-025 clr=1 SHALL have priority over push and pop. Next cycle: count=0, evt_valid=0, overflow=0, pointers=0. Any key_val in the clr cycle is discarded without setting bad_evt.
REQ-026 Back-to-back one-hot pulses on consecutive cycles SHALL each be enqueued while space remains.
REQ-027 All outputs SHALL be registered or derived only from registered state; no combinational path from key_val to any output.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL clear pointers and count. Next cycle: evt_valid=0, evt_code=0, evt_count=0, overflow=0, bad_evt=0.
REQ-029 rst SHALL override clr, key_val and evt_ready; entries pending when rst asserts mid-operation are discarded.
REQ-030 FIFO storage contents need not be reset; evt_code SHALL read 0 whenever evt_count=0.

Verification
REQ-031 Single event: empty queue, key_val=4'b0100 one cycle, evt_ready=0 -> next cycle evt_valid=1, evt_code=2, evt_count=1; holds until evt_ready=1, then evt_valid=0.
REQ-032 Order and wrap: push keys 0,1,2,3 on consecutive cycles (DEPTH=4), pop all, push 3,0 -> codes read out 0,1,2,3,3,0; count peaks at 4; overflow stays 0.
REQ-033 Overflow and simultaneous push/pop:
- fill to 4, then push 4'b0001 with evt_ready=0 -> dropped, overflow=1, count=4.
- then push 4'b0010 with evt_ready=1 -> pop and push both occur; count=4; last entry reads code 1.
REQ-034 Multi-hot: key_val=4'b0011 -> bad_evt=1 for one cycle, count unchanged; key_val=4'b1000 next -> enqueued, bad_evt=0.
REQ-035 clr: queue holds 3 entries, overflow=1; clr=1 with key_val=4'b0001 in the same cycle -> next cycle count=0, evt_valid=0, overflow=0, bad_evt=0.
REQ-036 Reset mid-operation: queue holds 2 entries, rst=1 one cycle with key_val=4'b0010 -> all outputs 0 next cycle; a subsequent push yields evt_code=1 at latency 1.
